// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM states, framing sizes
// and the modulo-256 checksum accumulator.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        CSUM  = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int CSUM_W     = 8;

    function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                   input logic [7:0]        b);
        return acc + b;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input, instruction-memory write port and processor-control lines
// of the program loader. The loader takes the slave side.
interface program_loader_if;

    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst_n;
    logic        done;
    logic        error;

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, cpu_rst_n, done, error
    );

    modport master (
        output start, in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, cpu_rst_n, done, error
    );

endinterface

// File: rtl/word_packer.sv
// Big-endian byte-to-word assembler: shifts bytes in MSB first and flags the
// byte that completes a 32-bit word.
module word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        last
);

    localparam int CNT_W = $clog2(WORD_BYTES);

    logic [CNT_W-1:0] cnt;
    logic [23:0]      partial;

    // The completed word is formed combinationally so the top can register it
    // on the same edge that accepts the final byte.
    assign word_next = {partial, byte_in};
    assign last      = byte_en && (cnt == CNT_W'(WORD_BYTES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            partial <= '0;
        end else if (clr) begin
            cnt     <= '0;
            partial <= '0;
        end else if (byte_en) begin
            partial <= word_next[23:0];
            cnt     <= last ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed, checksummed byte stream into instruction memory and
// releases the processor from reset only after a clean load.
module program_loader
    import loader_pkg::*;
#(
    parameter int          MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    program_loader_if.slave bus
);

    localparam int IDX_W = $clog2(MAX_WORDS + 1);
    localparam int HDR_W = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;

    state_t            state, next_state;
    logic [HDR_W-1:0]  hdr_cnt;
    logic [15:0]       n_words;
    logic [15:0]       n_cand;
    logic [IDX_W-1:0]  k;
    logic [CSUM_W-1:0] csum;
    logic [31:0]       word_next;
    logic              accept, start_ok, hdr_last, pk_en, pk_last, more_words;
    logic              in_ready_d, imem_we_d, cpu_rst_n_d, done_d, error_d;

    // in_ready is registered from the next state, so it always matches the
    // current state and accept needs no extra state qualification.
    assign accept     = bus.in_valid && bus.in_ready;
    assign start_ok   = bus.start && (state == IDLE || state == DONE || state == ERR);
    assign hdr_last   = (state == HDR) && accept && (hdr_cnt == HDR_W'(HDR_BYTES - 1));
    assign n_cand     = {n_words[7:0], bus.in_data};
    assign pk_en      = (state == DATA) && accept;
    assign more_words = (int'(k) + 1) < int'(n_words);

    word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_ok),
        .byte_en   (pk_en),
        .byte_in   (bus.in_data),
        .word_next (word_next),
        .last      (pk_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR: if (bus.start) next_state = HDR;
            HDR: if (hdr_last) begin
                if (int'(n_cand) > MAX_WORDS) next_state = ERR;
                else if (n_cand != 16'd0)     next_state = DATA;
                else                          next_state = CSUM;
            end
            DATA:  if (pk_last) next_state = WRITE;
            WRITE: next_state = more_words ? DATA : CSUM;
            CSUM:  if (accept) next_state = (bus.in_data == csum) ? DONE : ERR;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready_d  = (next_state == HDR) || (next_state == DATA) || (next_state == CSUM);
        imem_we_d   = (next_state == WRITE);
        done_d      = (next_state == DONE);
        error_d     = (next_state == ERR);
        cpu_rst_n_d = (next_state == DONE);
    end

    // ---- registered control outputs ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.in_ready  <= 1'b0;
            bus.imem_we   <= 1'b0;
            bus.done      <= 1'b0;
            bus.error     <= 1'b0;
            bus.cpu_rst_n <= 1'b0;
        end else begin
            bus.in_ready  <= in_ready_d;
            bus.imem_we   <= imem_we_d;
            bus.done      <= done_d;
            bus.error     <= error_d;
            bus.cpu_rst_n <= cpu_rst_n_d;
        end
    end

    // ---- header, counters, checksum and write port ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdr_cnt        <= '0;
            n_words        <= '0;
            k              <= '0;
            csum           <= '0;
            bus.imem_addr  <= BASE_ADDR;
            bus.imem_wdata <= '0;
        end else if (start_ok) begin
            hdr_cnt <= '0;
            n_words <= '0;
            k       <= '0;
            csum    <= '0;
        end else begin
            case (state)
                HDR: if (accept) begin
                    n_words <= n_cand;
                    hdr_cnt <= hdr_cnt + HDR_W'(1);
                end
                DATA: if (accept) begin
                    csum <= csum_add(csum, bus.in_data);
                    if (pk_last) begin
                        bus.imem_addr  <= BASE_ADDR + 32'({k, 2'b00});
                        bus.imem_wdata <= word_next;
                    end
                end
                WRITE: k <= k + IDX_W'(1);
                default: ;
            endcase
        end
    end

endmodule
